// File: rtl/action_collector.sv
`default_nettype none
// ============================================================================
// Module   : action_collector
// Purpose  : Gathers one lookup result per input into per-input slots, closes
//            the round when every slot is filled or the timeout expires, then
//            picks the winning matching action by priority and presents it on
//            a valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module action_collector #(
  parameter int         C_NUM_INPUTS       = 4,
  parameter int         C_OUT_PORT_WIDTH   = 8,
  parameter int         C_MATCH_ADDR_WIDTH = 10,
  parameter int         C_TIMEOUT          = 16,
  parameter logic [1:0] C_MISS_TYPE        = 2'b00
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [C_NUM_INPUTS-1:0]                    in_valid,
  input  logic [2*C_NUM_INPUTS-1:0]                  in_atype,
  input  logic [C_OUT_PORT_WIDTH*C_NUM_INPUTS-1:0]   in_port,
  input  logic [C_OUT_PORT_WIDTH*C_NUM_INPUTS-1:0]   in_vport,
  input  logic [C_NUM_INPUTS-1:0]                    in_match,
  input  logic [C_MATCH_ADDR_WIDTH*C_NUM_INPUTS-1:0] in_match_addr,
  input  logic                                       prio_mode,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [1:0]                                 out_atype,
  output logic [C_OUT_PORT_WIDTH-1:0]                out_port,
  output logic [C_OUT_PORT_WIDTH-1:0]                out_vport,
  output logic                                       out_match,
  output logic [C_MATCH_ADDR_WIDTH-1:0]              out_match_addr,
  output logic                                       out_timeout,
  output logic [15:0]                                timeout_count,
  output logic [15:0]                                overflow_count
);

  localparam int N  = C_NUM_INPUTS;
  localparam int W  = C_OUT_PORT_WIDTH;
  localparam int A  = C_MATCH_ADDR_WIDTH;
  localparam int TW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
  // Timer value seen in the last open cycle; the round closes on the next edge.
  localparam logic [TW-1:0] T_LAST = TW'((C_TIMEOUT > 0) ? (C_TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   filled_q, filled_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           timed_out_q, timed_out_d;
  logic [1:0]     slot_atype_q [N];
  logic [1:0]     slot_atype_d [N];
  logic [W-1:0]   slot_port_q  [N];
  logic [W-1:0]   slot_port_d  [N];
  logic [W-1:0]   slot_vport_q [N];
  logic [W-1:0]   slot_vport_d [N];
  logic [N-1:0]   slot_match_q, slot_match_d;
  logic [A-1:0]   slot_addr_q  [N];
  logic [A-1:0]   slot_addr_d  [N];

  logic           out_valid_q, out_valid_d;
  logic [1:0]     out_atype_q, out_atype_d;
  logic [W-1:0]   out_port_q, out_port_d;
  logic [W-1:0]   out_vport_q, out_vport_d;
  logic           out_match_q, out_match_d;
  logic [A-1:0]   out_addr_q, out_addr_d;
  logic           out_timeout_q, out_timeout_d;
  logic [15:0]    timeout_cnt_q, timeout_cnt_d;
  logic [15:0]    overflow_cnt_q, overflow_cnt_d;

  logic           sel_found;
  logic [1:0]     sel_atype;
  logic [W-1:0]   sel_port;
  logic [W-1:0]   sel_vport;
  logic [A-1:0]   sel_addr;
  logic           transfer;
  logic [N-1:0]   base_filled;
  logic [N-1:0]   accept;
  logic [N-1:0]   new_filled;
  state_t         eval_state;

  // Priority pick: low mode keeps the first hit, high mode lets later hits overwrite.
  always_comb begin
    sel_found = 1'b0;
    sel_atype = C_MISS_TYPE;
    sel_port  = '0;
    sel_vport = '0;
    sel_addr  = '0;
    for (int i = 0; i < N; i++) begin
      if (filled_q[i] && slot_match_q[i] && (prio_mode || !sel_found)) begin
        sel_found = 1'b1;
        sel_atype = slot_atype_q[i];
        sel_port  = slot_port_q[i];
        sel_vport = slot_vport_q[i];
        sel_addr  = slot_addr_q[i];
      end
    end
  end

  // Slot fill, round state machine, output register and event counters.
  always_comb begin
    state_d        = state_q;
    filled_d       = filled_q;
    timer_d        = timer_q;
    timed_out_d    = timed_out_q;
    slot_atype_d   = slot_atype_q;
    slot_port_d    = slot_port_q;
    slot_vport_d   = slot_vport_q;
    slot_match_d   = slot_match_q;
    slot_addr_d    = slot_addr_q;
    out_valid_d    = out_valid_q;
    out_atype_d    = out_atype_q;
    out_port_d     = out_port_q;
    out_vport_d    = out_vport_q;
    out_match_d    = out_match_q;
    out_addr_d     = out_addr_q;
    out_timeout_d  = out_timeout_q;
    timeout_cnt_d  = timeout_cnt_q;
    overflow_cnt_d = overflow_cnt_q;

    // A closed round moves out whenever the output register is empty or draining.
    transfer = (state_q == S_DONE) && (!out_valid_q || out_ready);

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (transfer) begin
      out_valid_d   = 1'b1;
      out_atype_d   = sel_atype;
      out_port_d    = sel_port;
      out_vport_d   = sel_vport;
      out_match_d   = sel_found;
      out_addr_d    = sel_addr;
      out_timeout_d = timed_out_q;
    end

    // On transfer the slots empty in the same cycle, so fresh strobes start a new round.
    base_filled = transfer ? '0 : filled_q;
    accept      = in_valid & ~base_filled;
    new_filled  = base_filled | accept;
    filled_d    = new_filled;

    if (|(in_valid & base_filled) && (overflow_cnt_q != 16'hFFFF)) begin
      overflow_cnt_d = overflow_cnt_q + 16'd1;
    end

    for (int i = 0; i < N; i++) begin
      if (accept[i]) begin
        slot_atype_d[i] = in_atype[2*i +: 2];
        slot_port_d[i]  = in_port[W*i +: W];
        slot_vport_d[i] = in_vport[W*i +: W];
        slot_match_d[i] = in_match[i];
        slot_addr_d[i]  = in_match_addr[A*i +: A];
      end
    end

    eval_state = transfer ? S_IDLE : state_q;
    case (eval_state)
      S_IDLE: begin
        state_d     = S_IDLE;
        timed_out_d = 1'b0;
        if (&new_filled) begin
          state_d = S_DONE;
        end else if (|new_filled) begin
          state_d = S_COLLECT;
          timer_d = '0;
        end
      end
      S_COLLECT: begin
        // A round that completes on the expiry cycle is a normal completion.
        if (&new_filled) begin
          state_d = S_DONE;
        end else if ((C_TIMEOUT > 0) && (timer_q == T_LAST)) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
          if (timeout_cnt_q != 16'hFFFF) begin
            timeout_cnt_d = timeout_cnt_q + 16'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_DONE;
      end
    endcase
  end

  // State and data registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      filled_q       <= '0;
      timer_q        <= '0;
      timed_out_q    <= 1'b0;
      slot_match_q   <= '0;
      for (int i = 0; i < N; i++) begin
        slot_atype_q[i] <= '0;
        slot_port_q[i]  <= '0;
        slot_vport_q[i] <= '0;
        slot_addr_q[i]  <= '0;
      end
      out_valid_q    <= 1'b0;
      out_atype_q    <= '0;
      out_port_q     <= '0;
      out_vport_q    <= '0;
      out_match_q    <= 1'b0;
      out_addr_q     <= '0;
      out_timeout_q  <= 1'b0;
      timeout_cnt_q  <= '0;
      overflow_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      filled_q       <= filled_d;
      timer_q        <= timer_d;
      timed_out_q    <= timed_out_d;
      slot_match_q   <= slot_match_d;
      for (int i = 0; i < N; i++) begin
        slot_atype_q[i] <= slot_atype_d[i];
        slot_port_q[i]  <= slot_port_d[i];
        slot_vport_q[i] <= slot_vport_d[i];
        slot_addr_q[i]  <= slot_addr_d[i];
      end
      out_valid_q    <= out_valid_d;
      out_atype_q    <= out_atype_d;
      out_port_q     <= out_port_d;
      out_vport_q    <= out_vport_d;
      out_match_q    <= out_match_d;
      out_addr_q     <= out_addr_d;
      out_timeout_q  <= out_timeout_d;
      timeout_cnt_q  <= timeout_cnt_d;
      overflow_cnt_q <= overflow_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_atype      = out_atype_q;
  assign out_port       = out_port_q;
  assign out_vport      = out_vport_q;
  assign out_match      = out_match_q;
  assign out_match_addr = out_addr_q;
  assign out_timeout    = out_timeout_q;
  assign timeout_count  = timeout_cnt_q;
  assign overflow_count = overflow_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_action_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_action_collector
// Purpose  : Directed scenarios plus randomized traffic for action_collector,
//            checked every cycle against a round-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_action_collector;

  localparam int         N    = 4;
  localparam int         W    = 8;
  localparam int         A    = 10;
  localparam int         T    = 16;
  localparam logic [1:0] MISS = 2'b00;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [2*N-1:0] in_atype = '0;
  logic [W*N-1:0] in_port = '0;
  logic [W*N-1:0] in_vport = '0;
  logic [N-1:0]   in_match = '0;
  logic [A*N-1:0] in_match_addr = '0;
  logic           prio_mode = 1'b0;
  logic           out_ready = 1'b1;
  logic           out_valid;
  logic [1:0]     out_atype;
  logic [W-1:0]   out_port;
  logic [W-1:0]   out_vport;
  logic           out_match;
  logic [A-1:0]   out_match_addr;
  logic           out_timeout;
  logic [15:0]    timeout_count;
  logic [15:0]    overflow_count;

  action_collector #(
    .C_NUM_INPUTS(N), .C_OUT_PORT_WIDTH(W), .C_MATCH_ADDR_WIDTH(A),
    .C_TIMEOUT(T), .C_MISS_TYPE(MISS)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_atype(in_atype),
    .in_port(in_port), .in_vport(in_vport), .in_match(in_match),
    .in_match_addr(in_match_addr), .prio_mode(prio_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_atype(out_atype),
    .out_port(out_port), .out_vport(out_vport), .out_match(out_match),
    .out_match_addr(out_match_addr), .out_timeout(out_timeout),
    .timeout_count(timeout_count), .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model: rounds of per-input results ----------------
  bit         m_full [N];
  logic [1:0] m_at [N];
  logic [W-1:0] m_pt [N];
  logic [W-1:0] m_vp [N];
  bit         m_mt [N];
  logic [A-1:0] m_ad [N];
  bit         m_open, m_done, m_to;
  int         m_open_at, cyc;
  bit         e_valid, e_match, e_to;
  logic [1:0] e_at;
  logic [W-1:0] e_pt, e_vp;
  logic [A-1:0] e_ad;
  int         e_tocnt, e_ovcnt;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_full[i] = 0;
    m_open = 0; m_done = 0; m_to = 0; m_open_at = 0;
    e_valid = 0; e_match = 0; e_to = 0; e_at = '0; e_pt = '0; e_vp = '0; e_ad = '0;
    e_tocnt = 0; e_ovcnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented now.
  task automatic model_edge();
    int  hits[$];
    int  w, nfull;
    bit  ovf;
    bit  free_out;
    free_out = !e_valid || out_ready;
    if (m_done && free_out) begin
      for (int i = 0; i < N; i++) if (m_full[i] && m_mt[i]) hits.push_back(i);
      if (hits.size() == 0) begin
        e_match = 0; e_at = MISS; e_pt = '0; e_vp = '0; e_ad = '0;
      end else begin
        w = prio_mode ? hits[hits.size()-1] : hits[0];
        e_match = 1; e_at = m_at[w]; e_pt = m_pt[w]; e_vp = m_vp[w]; e_ad = m_ad[w];
      end
      e_valid = 1; e_to = m_to;
      for (int i = 0; i < N; i++) m_full[i] = 0;
      m_done = 0; m_open = 0;
    end else if (e_valid && out_ready) begin
      e_valid = 0;
    end
    ovf = 0;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i]) begin
        if (m_full[i]) ovf = 1;
        else begin
          m_full[i] = 1;
          m_at[i] = in_atype[2*i +: 2];
          m_pt[i] = in_port[W*i +: W];
          m_vp[i] = in_vport[W*i +: W];
          m_mt[i] = in_match[i];
          m_ad[i] = in_match_addr[A*i +: A];
        end
      end
    end
    if (ovf && e_ovcnt < 65535) e_ovcnt++;
    if (!m_done) begin
      nfull = 0;
      for (int i = 0; i < N; i++) nfull += m_full[i];
      if (nfull == N) begin
        m_done = 1; m_to = 0;
      end else if (nfull > 0) begin
        if (!m_open) begin
          m_open = 1; m_open_at = cyc;
        end else if (T > 0 && cyc - m_open_at >= T) begin
          m_done = 1; m_to = 1;
          if (e_tocnt < 65535) e_tocnt++;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    check_value("out_valid", 32'(out_valid), 32'(e_valid));
    if (e_valid) begin
      check_value("out_atype", 32'(out_atype), 32'(e_at));
      check_value("out_port", 32'(out_port), 32'(e_pt));
      check_value("out_vport", 32'(out_vport), 32'(e_vp));
      check_value("out_match", 32'(out_match), 32'(e_match));
      check_value("out_match_addr", 32'(out_match_addr), 32'(e_ad));
      check_value("out_timeout", 32'(out_timeout), 32'(e_to));
    end
    check_value("timeout_count", 32'(timeout_count), 32'(e_tocnt));
    check_value("overflow_count", 32'(overflow_count), 32'(e_ovcnt));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_slot(input int i, input logic [1:0] at, input logic [W-1:0] pt,
                          input logic [W-1:0] vp, input bit mt, input logic [A-1:0] ad);
    in_valid[i]            = 1'b1;
    in_atype[2*i +: 2]     = at;
    in_port[W*i +: W]      = pt;
    in_vport[W*i +: W]     = vp;
    in_match[i]            = mt;
    in_match_addr[A*i +: A] = ad;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    in_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = '0;
    #2;
    model_reset();
    check_value("rst_out_valid", 32'(out_valid), 32'd0);
    check_value("rst_out_fields", {out_atype, out_port, out_vport, out_match, out_match_addr, out_timeout}, 32'd0);
    check_value("rst_counters", {timeout_count, overflow_count}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    cyc = 0;
    #1;
    do_reset();

    // Staggered arrivals 3,1,0,2 with hits on inputs 1 and 3, low then high priority.
    for (int pm = 0; pm < 2; pm++) begin
      prio_mode = pm[0];
      out_ready = 1'b1;
      set_slot(3, 2'd3, 8'h13, 8'h23, 1'b1, 10'h103); step();
      set_slot(1, 2'd1, 8'h11, 8'h21, 1'b1, 10'h101); step();
      set_slot(0, 2'd2, 8'h10, 8'h20, 1'b0, 10'h100); step();
      set_slot(2, 2'd2, 8'h12, 8'h22, 1'b0, 10'h102); step();
      check_value("lat_not_yet", 32'(out_valid), 32'd0);
      step();
      check_value("prio_valid", 32'(out_valid), 32'd1);
      check_value("prio_port", 32'(out_port), pm ? 32'h13 : 32'h11);
      check_value("prio_timeout", 32'(out_timeout), 32'd0);
      step();
    end

    // No input matches: miss action.
    for (int i = 0; i < N; i++) set_slot(i, 2'd3, 8'hFF, 8'hEE, 1'b0, 10'h3FF);
    step(); step();
    check_value("miss_match", 32'(out_match), 32'd0);
    check_value("miss_atype", 32'(out_atype), 32'(MISS));
    check_value("miss_fields", {out_port, out_vport, out_match_addr}, 32'd0);
    step();

    // Timeout: only inputs 0 and 2 report.
    do_reset();
    set_slot(0, 2'd1, 8'h30, 8'h40, 1'b0, 10'h050);
    set_slot(2, 2'd2, 8'h32, 8'h42, 1'b1, 10'h052);
    step();
    for (int k = 1; k < 17; k++) step();
    check_value("to_not_yet", 32'(out_valid), 32'd0);
    step();
    check_value("to_valid", 32'(out_valid), 32'd1);
    check_value("to_flag", 32'(out_timeout), 32'd1);
    check_value("to_port", 32'(out_port), 32'h32);
    check_value("to_count", 32'(timeout_count), 32'd1);
    step();

    // Back-pressure: two rounds queue up, an extra strobe overflows.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) set_slot(i, 2'd1, 8'hA0 + 8'(i), 8'h00, i == 2, 10'(i));
    step();
    for (int i = 0; i < N; i++) set_slot(i, 2'd2, 8'hB0 + 8'(i), 8'h01, i == 2, 10'(i));
    step();
    set_slot(0, 2'd3, 8'hC0, 8'h02, 1'b1, 10'h0);
    step();
    check_value("bp_overflow", 32'(overflow_count), 32'd1);
    for (int k = 0; k < 7; k++) begin
      step();
      check_value("bp_hold_port", 32'(out_port), 32'hA2);
    end
    out_ready = 1'b1;
    step();
    check_value("bp_second_port", 32'(out_port), 32'hB2);
    step();
    check_value("bp_drained", 32'(out_valid), 32'd0);

    // Reset mid-round discards partial data.
    set_slot(0, 2'd1, 8'h77, 8'h77, 1'b1, 10'h077);
    set_slot(1, 2'd1, 8'h78, 8'h78, 1'b1, 10'h078);
    step();
    do_reset();
    for (int i = 0; i < N; i++) set_slot(i, 2'd2, 8'h55 + 8'(i), 8'h66, i == 3, 10'h2AA);
    step(); step();
    check_value("rr_port", 32'(out_port), 32'h58);
    check_value("rr_counters", {timeout_count, overflow_count}, 32'd0);
    for (int k = 0; k < 3; k++) step();

    // Randomized traffic alternating dense and sparse arrival phases.
    for (int c = 0; c < 3000; c++) begin
      int dens;
      dens = ((c / 400) % 2 == 1) ? 40 : 4;
      out_ready = ($urandom_range(0, 9) < 7);
      prio_mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, dens - 1) == 0)
          set_slot(i, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 10'($urandom));
      end
      if (c == 1500) do_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
